// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants and decode-stage types.
// Opcodes, funct/REGIMM codes, FSM state, IF/ID bundle.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_JALR   = 6'b001001;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SLOT
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] next;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/branch_compare.sv
// Conditional-branch condition evaluation.
// Ports: opcode, rt field, rs_data, rt_data in; taken out.
module branch_compare
  import mips_isa_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        taken
);

  logic eq;
  logic neg;
  logic zero;

  assign eq   = (rs_data == rt_data);
  assign neg  = rs_data[31];
  assign zero = (rs_data == 32'd0);

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      opcode == OP_BEQ:  taken = eq;
      opcode == OP_BNE:  taken = ~eq;
      opcode == OP_BLEZ: taken = neg | zero;
      opcode == OP_BGTZ: taken = ~neg & ~zero;
      (opcode == OP_REGIMM) && (rt == RT_BLTZ):
        taken = neg;
      (opcode == OP_REGIMM) && (rt == RT_BGEZ):
        taken = ~neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_decode_redirect.sv
// Decode front end: IF/ID register, branch/jump redirect, slot FSM.
// Ports: fetch word/PC+4 and regfile data in; redirects, IF/ID, counters out.
module instruction_decode_redirect
  import mips_isa_pkg::*;
#(
  parameter int DELAY_SLOT = 0,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Instruction,
  input  logic [31:0]      NextInstruct,
  input  logic [31:0]      RsData,
  input  logic [31:0]      RtData,
  output logic [4:0]       RsAddr,
  output logic [4:0]       RtAddr,
  output logic             Branch,
  output logic             Jump,
  output logic             JumpSel,
  output logic [31:0]      InstructOffset,
  output logic [25:0]      JumpInstruction,
  output logic [31:0]      JumpRegister,
  output logic [31:0]      IDInstruction,
  output logic             IDValid,
  output logic [31:0]      LinkAddr,
  output logic [CNT_W-1:0] RedirectCount,
  output logic [CNT_W-1:0] SquashCount
);

  localparam logic DS = (DELAY_SLOT != 0);
  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_n;
  if_id_t           id;
  if_id_t           id_n;
  logic [CNT_W-1:0] rcnt;
  logic [CNT_W-1:0] scnt;
  logic [5:0]       op;
  logic [5:0]       fn;
  logic             taken;
  logic             jdec;
  logic             live;
  logic             redirect;

  assign op = id.instr[31:26];
  assign fn = id.instr[5:0];

  branch_compare u_cmp (
    .opcode  (op),
    .rt      (id.instr[20:16]),
    .rs_data (RsData),
    .rt_data (RtData),
    .taken   (taken)
  );

  assign jdec = (op == OP_J) || (op == OP_JAL) ||
    ((op == OP_RTYPE) &&
     ((fn == FN_JR) || (fn == FN_JALR)));

  // a delay-slot word must never steer fetch
  assign live     = id.valid && (state != SLOT);
  assign Branch   = live & taken;
  assign Jump     = live & jdec;
  assign JumpSel  = Jump & (op == OP_RTYPE);
  assign redirect = Branch | Jump;

  always_comb begin
    state_n = state;
    id_n    = '{instr: Instruction,
                next:  NextInstruct,
                valid: 1'b1};
    unique case (state)
      IDLE: state_n = RUN;
      RUN: begin
        if (redirect) begin
          if (DS) state_n = SLOT;
          else    id_n    = '0;
        end
      end
      SLOT:    state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      id    <= '0;
      rcnt  <= '0;
      scnt  <= '0;
    end else begin
      state <= state_n;
      id    <= id_n;
      if (redirect && !(&rcnt))
        rcnt <= rcnt + ONE;
      if (redirect && !DS && !(&scnt))
        scnt <= scnt + ONE;
    end
  end

  assign RsAddr          = id.instr[25:21];
  assign RtAddr          = id.instr[20:16];
  assign InstructOffset  = {{16{id.instr[15]}},
                            id.instr[15:0]};
  assign JumpInstruction = id.instr[25:0];
  assign JumpRegister    = RsData;
  assign IDInstruction   = id.instr;
  assign IDValid         = id.valid;
  assign LinkAddr        = DS ? id.next + 32'd4
                              : id.next;
  assign RedirectCount   = rcnt;
  assign SquashCount     = scnt;

endmodule

// File: tb/tb_instruction_decode_redirect.sv
// Bench for instruction_decode_redirect: three instances
// (slot squash, delay slot, 2-bit counters) vs. a behavioural model.
module tb_instruction_decode_redirect;

  logic        Clk;
  logic [2:0]  rst;
  logic [31:0] ins;
  logic [31:0] nx;
  logic [31:0] rsd;
  logic [31:0] rtd;

  logic [4:0]  rsa  [3];
  logic [4:0]  rta  [3];
  logic        br   [3];
  logic        jp   [3];
  logic        js   [3];
  logic [31:0] off  [3];
  logic [25:0] ji   [3];
  logic [31:0] jr_o [3];
  logic [31:0] idi  [3];
  logic        idv  [3];
  logic [31:0] la   [3];
  logic [15:0] rc0, sc0, rc1, sc1;
  logic [1:0]  rc2, sc2;

  int n_cmp;
  int n_bad;
  bit cmp_on;

  logic [31:0] m_instr [3];
  logic [31:0] m_next  [3];
  bit          m_valid [3];
  bit          m_slot  [3];
  int          m_rc    [3];
  int          m_sc    [3];

  instruction_decode_redirect #(.DELAY_SLOT(0), .CNT_W(16)) d0 (
    .Clk(Clk), .Reset(rst[0]), .Instruction(ins),
    .NextInstruct(nx), .RsData(rsd), .RtData(rtd),
    .RsAddr(rsa[0]), .RtAddr(rta[0]), .Branch(br[0]),
    .Jump(jp[0]), .JumpSel(js[0]), .InstructOffset(off[0]),
    .JumpInstruction(ji[0]), .JumpRegister(jr_o[0]),
    .IDInstruction(idi[0]), .IDValid(idv[0]),
    .LinkAddr(la[0]), .RedirectCount(rc0), .SquashCount(sc0));

  instruction_decode_redirect #(.DELAY_SLOT(1), .CNT_W(16)) d1 (
    .Clk(Clk), .Reset(rst[1]), .Instruction(ins),
    .NextInstruct(nx), .RsData(rsd), .RtData(rtd),
    .RsAddr(rsa[1]), .RtAddr(rta[1]), .Branch(br[1]),
    .Jump(jp[1]), .JumpSel(js[1]), .InstructOffset(off[1]),
    .JumpInstruction(ji[1]), .JumpRegister(jr_o[1]),
    .IDInstruction(idi[1]), .IDValid(idv[1]),
    .LinkAddr(la[1]), .RedirectCount(rc1), .SquashCount(sc1));

  instruction_decode_redirect #(.DELAY_SLOT(0), .CNT_W(2)) d2 (
    .Clk(Clk), .Reset(rst[2]), .Instruction(ins),
    .NextInstruct(nx), .RsData(rsd), .RtData(rtd),
    .RsAddr(rsa[2]), .RtAddr(rta[2]), .Branch(br[2]),
    .Jump(jp[2]), .JumpSel(js[2]), .InstructOffset(off[2]),
    .JumpInstruction(ji[2]), .JumpRegister(jr_o[2]),
    .IDInstruction(idi[2]), .IDValid(idv[2]),
    .LinkAddr(la[2]), .RedirectCount(rc2), .SquashCount(sc2));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int is_ds(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int cmax(input int i);
    return (i == 2) ? 3 : 65535;
  endfunction

  function automatic logic [31:0] rc_of(input int i);
    case (i)
      0:       return {16'd0, rc0};
      1:       return {16'd0, rc1};
      default: return {30'd0, rc2};
    endcase
  endfunction

  function automatic logic [31:0] sc_of(input int i);
    case (i)
      0:       return {16'd0, sc0};
      1:       return {16'd0, sc1};
      default: return {30'd0, sc2};
    endcase
  endfunction

  // branch rules straight from the ISA, using signed integer compares
  function automatic bit exp_taken(input logic [31:0] w,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    int sa;
    sa = $signed(a);
    case (w[31:26])
      6'd4: return a == b;
      6'd5: return a != b;
      6'd6: return sa <= 0;
      6'd7: return sa > 0;
      6'd1: begin
        if (w[20:16] == 5'd0) return sa < 0;
        if (w[20:16] == 5'd1) return sa >= 0;
        return 1'b0;
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_jump(input logic [31:0] w);
    if (w[31:26] == 6'd2 || w[31:26] == 6'd3) return 1'b1;
    return (w[31:26] == 6'd0) &&
           (w[5:0] == 6'd8 || w[5:0] == 6'd9);
  endfunction

  function automatic bit m_act(input int i);
    return m_valid[i] && !m_slot[i];
  endfunction

  function automatic bit m_redirect(input int i);
    return m_act(i) &&
      (exp_taken(m_instr[i], rsd, rtd) || exp_jump(m_instr[i]));
  endfunction

  always @(posedge Clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst[i]) begin
        m_instr[i] <= 32'd0;
        m_next[i]  <= 32'd0;
        m_valid[i] <= 1'b0;
        m_slot[i]  <= 1'b0;
        m_rc[i]    <= 0;
        m_sc[i]    <= 0;
      end else begin
        if (m_redirect(i))
          m_rc[i] <= (m_rc[i] < cmax(i)) ? m_rc[i] + 1 : m_rc[i];
        if (m_redirect(i) && is_ds(i) == 0) begin
          m_instr[i] <= 32'd0;
          m_next[i]  <= 32'd0;
          m_valid[i] <= 1'b0;
          m_slot[i]  <= 1'b0;
          m_sc[i]    <= (m_sc[i] < cmax(i)) ? m_sc[i] + 1 : m_sc[i];
        end else begin
          m_instr[i] <= ins;
          m_next[i]  <= nx;
          m_valid[i] <= 1'b1;
          m_slot[i]  <= m_redirect(i);
        end
      end
    end
  end

  task automatic chk(input string nm, input int i,
                     input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h",
               nm, i, $time, a, e);
    end
  endtask

  task automatic cyc(input logic [31:0] w, input logic [31:0] n,
                     input logic [31:0] a, input logic [31:0] b);
    @(posedge Clk);
    #1;
    ins = w;
    nx  = n;
    rsd = a;
    rtd = b;
    @(negedge Clk);
  endtask

  task automatic cmp_all();
    logic [31:0] w;
    logic signed [31:0] so;
    bit e_br, e_jp;
    for (int i = 0; i < 3; i++) begin
      w    = m_instr[i];
      so   = $signed(w[15:0]);
      e_br = m_act(i) && exp_taken(w, rsd, rtd);
      e_jp = m_act(i) && exp_jump(w);
      chk("Branch", i, {31'd0, br[i]}, {31'd0, e_br});
      chk("Jump", i, {31'd0, jp[i]}, {31'd0, e_jp});
      chk("JumpSel", i, {31'd0, js[i]},
          {31'd0, e_jp && (w[31:26] == 6'd0)});
      chk("NotBoth", i, {31'd0, br[i] & jp[i]}, 32'd0);
      chk("Offset", i, off[i], so);
      chk("JumpInstr", i, {6'd0, ji[i]}, {6'd0, w[25:0]});
      chk("JumpReg", i, jr_o[i], rsd);
      chk("RsAddr", i, {27'd0, rsa[i]}, {27'd0, w[25:21]});
      chk("RtAddr", i, {27'd0, rta[i]}, {27'd0, w[20:16]});
      chk("IDInstr", i, idi[i], w);
      chk("IDValid", i, {31'd0, idv[i]}, {31'd0, m_valid[i]});
      chk("LinkAddr", i, la[i],
          m_next[i] + ((is_ds(i) != 0) ? 32'd4 : 32'd0));
      chk("RedirCnt", i, rc_of(i), m_rc[i]);
      chk("SquashCnt", i, sc_of(i), m_sc[i]);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    cmp_on = 1'b0;
    rst    = 3'b000;
    ins    = 32'h2001_0005;
    nx     = 32'h0000_0104;
    rsd    = 32'd0;
    rtd    = 32'd0;

    fork
      forever begin
        @(negedge Clk);
        if (cmp_on) cmp_all();
      end
    join_none

    @(negedge Clk);
    cmp_on = 1'b1;
    @(negedge Clk);
    chk("rst_IDInstr", 0, idi[0], 32'd0);
    chk("rst_IDValid", 0, {31'd0, idv[0]}, 32'd0);
    chk("rst_Branch", 0, {31'd0, br[0]}, 32'd0);
    chk("rst_Redir", 0, rc_of(0), 32'd0);
    rst[0] = 1'b1;

    // squash mode: addi, beq taken, bne taken/not, jr, jal
    cyc(32'h1022_0003, 32'h108, 0, 0);
    chk("first_IDInstr", 0, idi[0], 32'h2001_0005);
    chk("first_IDValid", 0, {31'd0, idv[0]}, 32'd1);
    chk("first_noRedir", 0, {30'd0, br[0], jp[0]}, 32'd0);
    cyc(32'h2003_0001, 32'h10C, 5, 5);
    chk("beq_Branch", 0, {31'd0, br[0]}, 32'd1);
    chk("beq_Offset", 0, off[0], 32'h0000_0003);
    cyc(32'h1422_FFFE, 32'h11C, 0, 0);
    chk("sq_IDValid", 0, {31'd0, idv[0]}, 32'd0);
    chk("sq_Squash", 0, sc_of(0), 32'd1);
    chk("sq_Redir", 0, rc_of(0), 32'd1);
    cyc(32'h03E0_0008, 32'h120, 5, 6);
    chk("bne_Branch", 0, {31'd0, br[0]}, 32'd1);
    chk("bne_Offset", 0, off[0], 32'hFFFF_FFFE);
    cyc(32'h1422_FFFE, 32'h124, 0, 0);
    cyc(32'h03E0_0008, 32'h128, 5, 5);
    chk("bne_eq_Branch", 0, {31'd0, br[0]}, 32'd0);
    cyc(32'h0C00_0010, 32'h12C, 32'h40, 0);
    chk("bne_eq_noSq", 0, sc_of(0), 32'd2);
    chk("jr_Jump", 0, {31'd0, jp[0]}, 32'd1);
    chk("jr_JumpSel", 0, {31'd0, js[0]}, 32'd1);
    chk("jr_JumpReg", 0, jr_o[0], 32'h40);
    cyc(32'h0C00_0010, 32'h130, 0, 0);
    cyc(32'h0000_0000, 32'h134, 0, 0);
    chk("jal_Jump", 0, {31'd0, jp[0]}, 32'd1);
    chk("jal_JumpSel", 0, {31'd0, js[0]}, 32'd0);
    chk("jal_JumpInstr", 0, {6'd0, ji[0]}, 32'h10);
    chk("jal_Link", 0, la[0], 32'h130);
    cyc(32'h0000_0000, 32'h138, 0, 0);
    chk("a_Redir", 0, rc_of(0), 32'd4);
    chk("a_Squash", 0, sc_of(0), 32'd4);

    // delay-slot mode: j, beq in slot (not acted on), jal link
    cyc(32'h0800_0020, 32'h200, 0, 0);
    rst[1] = 1'b1;
    cyc(32'h1022_0003, 32'h204, 0, 0);
    chk("ds_j_Jump", 1, {31'd0, jp[1]}, 32'd1);
    chk("ds_j_JumpSel", 1, {31'd0, js[1]}, 32'd0);
    cyc(32'h0C00_0040, 32'h084, 7, 7);
    chk("ds_slot_Instr", 1, idi[1], 32'h1022_0003);
    chk("ds_slot_Valid", 1, {31'd0, idv[1]}, 32'd1);
    chk("ds_slot_Branch", 1, {31'd0, br[1]}, 32'd0);
    chk("ds_slot_Redir", 1, rc_of(1), 32'd1);
    chk("ds_slot_Squash", 1, sc_of(1), 32'd0);
    cyc(32'h0000_0000, 32'h088, 0, 0);
    chk("ds_jal_Jump", 1, {31'd0, jp[1]}, 32'd1);
    chk("ds_jal_Link", 1, la[1], 32'h088);
    cyc(32'h0000_0000, 32'h08C, 0, 0);
    chk("ds_Redir", 1, rc_of(1), 32'd2);
    chk("ds_Squash", 1, sc_of(1), 32'd0);

    // 2-bit counters saturate
    cyc(32'h0800_0020, 32'h300, 0, 0);
    rst[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(32'h0800_0020, 32'h300, 0, 0);
      if (k == 1) chk("c2_Redir1", 2, rc_of(2), 32'd1);
    end
    chk("sat_Redir", 2, rc_of(2), 32'd3);
    chk("sat_Squash", 2, sc_of(2), 32'd3);

    // asynchronous reset while a branch is being issued
    cyc(32'h0000_0000, 32'h400, 0, 0);
    cyc(32'h0000_0000, 32'h404, 0, 0);
    cyc(32'h1022_0003, 32'h408, 0, 0);
    cyc(32'h0000_0000, 32'h40C, 5, 5);
    chk("pre_rst_Branch", 0, {31'd0, br[0]}, 32'd1);
    #2;
    rst[0] = 1'b0;
    #1;
    chk("arst_Branch", 0, {31'd0, br[0]}, 32'd0);
    chk("arst_IDValid", 0, {31'd0, idv[0]}, 32'd0);
    chk("arst_IDInstr", 0, idi[0], 32'd0);
    chk("arst_Offset", 0, off[0], 32'd0);
    chk("arst_Redir", 0, rc_of(0), 32'd0);
    chk("arst_Squash", 0, sc_of(0), 32'd0);
    cyc(32'h0000_0000, 32'h410, 0, 0);
    chk("idle_IDValid", 0, {31'd0, idv[0]}, 32'd0);
    rst[0] = 1'b1;
    cyc(32'h0000_0000, 32'h414, 0, 0);
    chk("rerun_IDValid", 0, {31'd0, idv[0]}, 32'd1);
    chk("rerun_Redir", 0, rc_of(0), 32'd0);
    cyc(32'h0000_0000, 32'h418, 0, 0);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_decode_redirect.md
# instruction_decode_redirect

Decode-stage front end that consumes the fetch unit's `Instruction` / `NextInstruct` pair. It holds them in an IF/ID pipeline register and decodes control-flow instructions against register-file operands. It drives the fetch unit's redirect inputs (`Branch`, `Jump`, `JumpSel`, `InstructOffset`, `JumpInstruction`, `JumpRegister`). A small FSM squashes or keeps the wrong-path slot and suppresses redirects from invalid or delay-slot instructions.

## Interface
Parameters:
- `DELAY_SLOT`, default 0: 1 = MIPS delay-slot semantics (slot kept); 0 = slot squashed.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `Clk` in 1: sole clock, rising edge.
- `Reset` in 1: asynchronous, active-low; 0 clears all state.
- `Instruction` in 32: word currently output by fetch.
- `NextInstruct` in 32: fetch PC+4 for that word.
- `RsData` in 32: register-file read of `RsAddr`, combinational.
- `RtData` in 32: register-file read of `RtAddr`, combinational.
- `RsAddr` out 5: `IDInstruction[25:21]`.
- `RtAddr` out 5: `IDInstruction[20:16]`.
- `Branch` out 1: conditional branch taken; fetch selects PC+4+offset<<2.
- `Jump` out 1: unconditional jump.
- `JumpSel` out 1: 1 = register target (`JumpRegister`), 0 = 26-bit target.
- `InstructOffset` out 32: sign-extended `IDInstruction[15:0]`.
- `JumpInstruction` out 26: `IDInstruction[25:0]`.
- `JumpRegister` out 32: `RsData`.
- `IDInstruction` out 32: IF/ID instruction register.
- `IDValid` out 1: IF/ID holds a live instruction.
- `LinkAddr` out 32: `IDNextInstruct + 4` if `DELAY_SLOT`, else `IDNextInstruct`.
- `RedirectCount` out CNT_W: redirects issued, saturating.
- `SquashCount` out CNT_W: slots squashed, saturating.

## Operation
- Decoded redirect sources:
  - beq (000100): Rs==Rt.
  - bne (000101): Rs!=Rt.
  - blez (000110): Rs signed <= 0.
  - bgtz (000111): Rs signed > 0.
  - REGIMM (000001) with rt=00000: bltz.
  - REGIMM (000001) with rt=00001: bgez.
  - j (000010) and jal (000011): `Jump`=1, `JumpSel`=0.
  - R-type (000000) with funct 001000 (jr) or 001001 (jalr): `Jump`=1, `JumpSel`=1.
- `Branch`/`Jump` are gated: asserted only when `IDValid`=1 and state is not SLOT. Combinational from IF/ID plus `RsData`/`RtData`.
- `Branch` and `Jump` are never both 1. `InstructOffset`, `JumpInstruction` and `JumpRegister` are driven unconditionally.
- FSM states:
  - IDLE: after reset.
  - RUN: normal decode.
  - SLOT: delay slot in ID; used only when `DELAY_SLOT`=1.
- FSM transitions:
  - IDLE → RUN on the first edge after `Reset` deasserts. IF/ID loads the fetched word with `IDValid`=1.
  - RUN with a redirect and `DELAY_SLOT`=0: IF/ID loads 0x00000000, `IDValid`←0, `SquashCount`++, stay RUN.
  - RUN with a redirect and `DELAY_SLOT`=1: IF/ID loads the slot word, `IDValid`←1, → SLOT.
  - SLOT → RUN unconditionally. Any branch/jump decoded in SLOT is not acted on.
  - Otherwise IF/ID loads `Instruction`/`NextInstruct` with `IDValid`←1.
- `RedirectCount`++ on every edge where `Branch|Jump`=1. Both counters saturate at all-ones.

## Timing
- Reset (asynchronous, `Reset`=0) clears:
  - IF/ID instruction, `IDNextInstruct`, `IDValid`, both counters → 0.
  - state → IDLE.
- Consequences of reset:
  - All redirect outputs are 0.
  - `InstructOffset`/`JumpInstruction` read 0 because IF/ID is 0.
  - Reset mid-redirect aborts it. No count is recorded.
- Fetch→ID latency: 1 cycle. A redirect decoded in cycle n steers the PC at edge n. The target instruction is in ID at cycle n+2.
- Fetch computes the branch target from its PCOut, which equals the branch's PC+4 while the branch is in ID. No adjustment is made here.
- Back-to-back redirects:
  - `DELAY_SLOT`=0: the squashed slot can never redirect, because `IDValid`=0.
  - `DELAY_SLOT`=1: the SLOT state blocks redirects.
- `IDValid`=0 holds a NOP. Downstream treats it as a bubble.

## Structure
- Shared package `mips_isa_pkg` holds:
  - opcode constants OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ;
  - funct constants FN_JR, FN_JALR;
  - REGIMM rt codes;
  - the FSM state typedef.
- One sub-module, `branch_compare`: combinational; inputs opcode, rt field, `RsData`, `RtData`; output `taken`.

## Test plan
- Reset released with `Instruction`=0x20010005: IDLE one cycle, then `IDInstruction`=0x20010005, `IDValid`=1, `Branch`=`Jump`=0.
- `DELAY_SLOT`=0, beq 0x10220003 with `RsData`=`RtData`=5: `Branch`=1, `InstructOffset`=0x00000003. Next cycle `IDValid`=0; `SquashCount`=1, `RedirectCount`=1.
- bne 0x1422FFFE with Rs=5, Rt=6: `Branch`=1, `InstructOffset`=0xFFFFFFFE. Same word with Rs=Rt: `Branch`=0 and no squash.
- jr 0x03E00008 with `RsData`=0x00000040: `Jump`=1, `JumpSel`=1, `JumpRegister`=0x40. jal 0x0C000010: `Jump`=1, `JumpSel`=0, `JumpInstruction`=0x0000010.
- `DELAY_SLOT`=1, j followed by beq in the slot with Rs=Rt: j redirects; slot beq has `IDValid`=1 and `Branch`=0. `RedirectCount`=1, `SquashCount`=0. jal `LinkAddr` = `IDNextInstruct`+4.
- `Reset` pulsed low mid-cycle while `Branch`=1: outputs drop to 0 asynchronously, counters=0, state IDLE. With `CNT_W`=2, four redirects leave `RedirectCount`=3.
